// File: rtl/dc_mem_arbiter.sv
// rtl/dc_mem_arbiter.sv - data-counter memory arbiter with irq override and block stream engine
//
// Purpose: owns DC_COUNT address counters (DCs) and shares one memory read port
// and one memory write port between the interrupt reload, CPU-style ops and a
// linear block stream. Priority per cycle: reset > irq > accepted op > stream.
//
// Ports:
//   clk, reset                       rising-edge clock, synchronous active-high reset
//   op_valid/op_ready, op, op_sel,   op handshake, opcode, DC index,
//   op_addr, op_data                 absolute address and write data
//   irq, irq_addr                    level interrupt, new DC0 value
//   strm_start, strm_dir, strm_base, stream launch (dir 1 = into memory)
//   strm_len, strm_wdata,            stream write data handshake and status
//   strm_wvalid/strm_wready,
//   strm_busy, strm_done
//   mem_we, mem_waddr, mem_wdata     memory write port
//   mem_re, mem_raddr, mem_rdata     memory read port (rdata one cycle after re)
//   rd_valid, rd_tag, rd_sel,        read return with source tag
//   rd_data
//   dc_addr, dc_dir, dc_mod          registered DC state
//   irq_conflict                     irq is blocking a valid read-port op

module dc_mem_arbiter #(
  parameter int MAIN_ADDR_WIDTH = 16,
  parameter int WORD_WIDTH      = 32,
  parameter int DC_COUNT        = 4,
  parameter int LEN_WIDTH       = 16,
  localparam int SEL_WIDTH      = $clog2(DC_COUNT)
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      op_valid,
  output logic                                      op_ready,
  input  logic [2:0]                                op,
  input  logic [SEL_WIDTH-1:0]                      op_sel,
  input  logic [MAIN_ADDR_WIDTH-1:0]                op_addr,
  input  logic [WORD_WIDTH-1:0]                     op_data,
  input  logic                                      irq,
  input  logic [MAIN_ADDR_WIDTH-1:0]                irq_addr,
  input  logic                                      strm_start,
  input  logic                                      strm_dir,
  input  logic [MAIN_ADDR_WIDTH-1:0]                strm_base,
  input  logic [LEN_WIDTH-1:0]                      strm_len,
  input  logic [WORD_WIDTH-1:0]                     strm_wdata,
  input  logic                                      strm_wvalid,
  output logic                                      strm_wready,
  output logic                                      strm_busy,
  output logic                                      strm_done,
  output logic                                      mem_we,
  output logic [MAIN_ADDR_WIDTH-1:0]                mem_waddr,
  output logic [WORD_WIDTH-1:0]                     mem_wdata,
  output logic                                      mem_re,
  output logic [MAIN_ADDR_WIDTH-1:0]                mem_raddr,
  input  logic [WORD_WIDTH-1:0]                     mem_rdata,
  output logic                                      rd_valid,
  output logic [1:0]                                rd_tag,
  output logic [SEL_WIDTH-1:0]                      rd_sel,
  output logic [WORD_WIDTH-1:0]                     rd_data,
  output logic [DC_COUNT-1:0][MAIN_ADDR_WIDTH-1:0]  dc_addr,
  output logic [DC_COUNT-1:0]                       dc_dir,
  output logic [DC_COUNT-1:0]                       dc_mod,
  output logic                                      irq_conflict
);

  localparam int A = MAIN_ADDR_WIDTH;

  localparam logic [2:0] OP_NOP       = 3'd0;
  localparam logic [2:0] OP_READ_DC   = 3'd1;
  localparam logic [2:0] OP_WRITE_DC  = 3'd2;
  localparam logic [2:0] OP_SETF      = 3'd3;
  localparam logic [2:0] OP_SETB      = 3'd4;
  localparam logic [2:0] OP_READ_STK  = 3'd5;
  localparam logic [2:0] OP_READ_CONV = 3'd6;
  localparam logic [2:0] OP_WRITE_ABS = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} strm_state_t;

  strm_state_t                       state_q, state_d;
  logic [DC_COUNT-1:0][A-1:0]        dc_q, dc_d;
  logic [DC_COUNT-1:0]               dir_q, dir_d;
  logic [DC_COUNT-1:0]               mod_q, mod_d;
  logic [A-1:0]                      saddr_q, saddr_d;
  logic [LEN_WIDTH-1:0]              scount_q, scount_d;
  logic                              sdir_q, sdir_d;
  logic                              rd_valid_q, rd_valid_d;
  logic [1:0]                        rd_tag_q, rd_tag_d;
  logic [SEL_WIDTH-1:0]              rd_sel_q, rd_sel_d;

  logic                              op_uses_no_read;
  logic                              op_acc;
  logic                              strm_fire;
  logic [A-1:0]                      nxt_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      dc_q       <= '0;
      dir_q      <= '0;
      mod_q      <= '0;
      saddr_q    <= '0;
      scount_q   <= '0;
      sdir_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_tag_q   <= 2'd0;
      rd_sel_q   <= '0;
    end else begin
      state_q    <= state_d;
      dc_q       <= dc_d;
      dir_q      <= dir_d;
      mod_q      <= mod_d;
      saddr_q    <= saddr_d;
      scount_q   <= scount_d;
      sdir_q     <= sdir_d;
      rd_valid_q <= rd_valid_d;
      rd_tag_q   <= rd_tag_d;
      rd_sel_q   <= rd_sel_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    dc_d         = dc_q;
    dir_d        = dir_q;
    mod_d        = mod_q;
    saddr_d      = saddr_q;
    scount_d     = scount_q;
    sdir_d       = sdir_q;
    rd_tag_d     = 2'd0;
    rd_sel_d     = '0;
    mem_we       = 1'b0;
    mem_waddr    = '0;
    mem_wdata    = '0;
    mem_re       = 1'b0;
    mem_raddr    = '0;
    op_ready     = 1'b0;
    irq_conflict = 1'b0;
    strm_wready  = 1'b0;
    strm_fire    = 1'b0;
    nxt_addr     = '0;

    // NOP and WRITE_ABS never touch the read port, so they can ride along with irq.
    op_uses_no_read = (op == OP_NOP) || (op == OP_WRITE_ABS);

    if (!reset) begin
      op_ready     = !irq || op_uses_no_read;
      irq_conflict = irq && op_valid && !op_uses_no_read;
    end
    op_acc = op_valid && op_ready;

    if (!reset) begin
      if (irq) begin
        dc_d[0]   = irq_addr;
        dir_d[0]  = 1'b0;
        mem_re    = 1'b1;
        mem_raddr = irq_addr;
      end

      if (op_acc) begin
        case (op)
          OP_READ_DC: begin
            nxt_addr       = dc_q[op_sel] + A'(1);
            dc_d[op_sel]   = nxt_addr;
            mem_re         = 1'b1;
            mem_raddr      = nxt_addr;
            rd_sel_d       = op_sel;
          end
          OP_WRITE_DC: begin
            // Backward counters pre-decrement, forward counters post-increment.
            if (dir_q[op_sel]) begin
              nxt_addr  = dc_q[op_sel] - A'(1);
              mem_waddr = nxt_addr;
            end else begin
              nxt_addr  = dc_q[op_sel] + A'(1);
              mem_waddr = dc_q[op_sel];
            end
            mem_we       = 1'b1;
            mem_wdata    = op_data;
            dc_d[op_sel] = nxt_addr;
            mem_re       = 1'b1;
            mem_raddr    = nxt_addr;
            rd_sel_d     = op_sel;
          end
          OP_SETF, OP_SETB: begin
            dc_d[op_sel]  = op_addr;
            dir_d[op_sel] = (op == OP_SETB);
            mod_d[op_sel] = 1'b1;
            mem_re        = 1'b1;
            mem_raddr     = op_addr;
            rd_sel_d      = op_sel;
          end
          OP_READ_STK, OP_READ_CONV: begin
            mem_re    = 1'b1;
            mem_raddr = op_addr;
            rd_tag_d  = (op == OP_READ_STK) ? 2'd1 : 2'd2;
          end
          OP_WRITE_ABS: begin
            mem_we    = 1'b1;
            mem_waddr = op_addr;
            mem_wdata = op_data;
          end
          default: ;
        endcase
      end

      case (state_q)
        S_IDLE: begin
          if (strm_start) begin
            saddr_d  = strm_base;
            scount_d = strm_len;
            sdir_d   = strm_dir;
            state_d  = (strm_len == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (!irq) begin
            if (sdir_q) begin
              if (!mem_we) begin
                strm_wready = 1'b1;
                if (strm_wvalid) begin
                  mem_we    = 1'b1;
                  mem_waddr = saddr_q;
                  mem_wdata = strm_wdata;
                  strm_fire = 1'b1;
                end
              end
            end else if (!mem_re) begin
              mem_re    = 1'b1;
              mem_raddr = saddr_q;
              rd_tag_d  = 2'd3;
              strm_fire = 1'b1;
            end
          end
          if (strm_fire) begin
            saddr_d  = saddr_q + A'(1);
            scount_d = scount_q - LEN_WIDTH'(1);
            if (scount_q == LEN_WIDTH'(1)) state_d = S_DONE;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    rd_valid_d = mem_re;
  end

  // Gating with reset drops a read return that was in flight when reset hit.
  assign rd_valid  = rd_valid_q && !reset;
  assign rd_tag    = rd_tag_q;
  assign rd_sel    = rd_sel_q;
  assign rd_data   = mem_rdata;
  assign strm_busy = (state_q != S_IDLE);
  assign strm_done = (state_q == S_DONE) && !reset;
  assign dc_addr   = dc_q;
  assign dc_dir    = dir_q;
  assign dc_mod    = mod_q;

endmodule
